uart_autobaud: RTL and testbench
================================

# uart_autobaud

Automatic baud-rate detector for the UART receive path. It measures the line timing of a 0x55 sync character on the raw RX pin and computes the 16-bit divider that the prescaler consumes. Its output lets the receiver and transmitter lock to an unknown remote baud rate without software calibration. It sits between the RX pad and the prescaler's scale-factor input; software or a link-training controller arms it.

## Interface
Parameters:
- InitialDivider, 16: value of o_scaler out of reset and until the first successful detection.
- OverSample, 8: prescaler ticks per bit. Power of two, 1..64. o_scaler is expressed in clocks per tick.
- MaxInterval, 262143: timeout for the first falling-edge interval, in clocks. At most 2^20-1.

Ports:
- i_clk, in, 1: clock.
- i_rst, in, 1: synchronous, active-high reset.
- i_rx, in, 1: raw asynchronous serial line, idle high.
- i_arm, in, 1: single-cycle request to start one detection.
- o_busy, out, 1: high from arm acceptance until the result or error pulse.
- o_scaler, out, 16: last successfully detected divider. Held between detections.
- o_valid, out, 1: one-cycle pulse when o_scaler is updated.
- o_error, out, 1: one-cycle pulse when a detection is aborted.

## Operation
- i_rx passes through a 2-flop synchronizer, giving rx_s, then one more flop, giving rx_q.
- A falling edge is the cycle where rx_q=1 and rx_s=0.
- The 0x55 frame, sent LSB first, has falling edges at bit positions 0, 2, 4, 6 and 8. The four intervals between them each span 2 bit periods, and their sum spans 8 bit periods.
- Interval counter: set to 1 on every falling edge, then +1 per cycle. At the next edge, its value is the interval in clocks.
- States:
  - IDLE. Outputs are quiet. i_arm moves to WAIT_HIGH.
  - WAIT_HIGH. When rx_s=1, go to WAIT_EDGE.
  - WAIT_EDGE. On a falling edge, clear the interval counter and the edge index, then go to MEASURE. There is no timeout in this state.
  - MEASURE:
    - First interval: latched as I0 and added to the total.
    - Intervals 2..4: each must satisfy |Ik − I0| ≤ I0>>2 (inclusive). If it passes, add Ik to the total. If it fails, abort.
    - Timeout while waiting for interval 1: counter exceeds MaxInterval. Abort.
    - Timeout while waiting for intervals 2..4: counter exceeds I0 + (I0>>2). Abort.
    - After the 4th interval is accepted, go to RESULT.
  - RESULT: one cycle. Compute S = 3 + log2(OverSample) and R = (total + 2^(S−1)) >> S. If 2 ≤ R ≤ 16'hFFFF, then o_scaler ← R[15:0], pulse o_valid and go to IDLE. Otherwise abort.
- Abort: pulse o_error for one cycle, go to IDLE, and leave o_scaler unchanged.
- Arithmetic widths: the interval counter is 20 bits and saturates at all-ones. The total is 23 bits. The tolerance compare is unsigned and done at 21 bits, so it cannot overflow.
- i_arm is ignored when not in IDLE. An i_arm in the same cycle as an o_valid or o_error pulse is also ignored.
- The stop bit is not checked. Detection completes at the 5th falling edge.

## Timing
- Reset values: o_busy=0, o_valid=0, o_error=0, o_scaler=InitialDivider, state=IDLE, synchronizer flops=1.
- o_busy rises the cycle after i_arm is sampled. It falls in the same cycle that o_valid or o_error is asserted.
- Latency:
  - A falling edge on i_rx is detected 3 cycles after it is sampled (2 synchronizer flops plus the rx_q flop).
  - o_valid is asserted 1 cycle after the 5th detected edge.
  - o_scaler changes in the same cycle o_valid is high.
- o_valid and o_error are never high together and are never high for more than 1 cycle.
- Reset mid-detection has priority: everything returns to reset values on the next edge, and no pulse is emitted. This includes restoring o_scaler to InitialDivider.
- A timeout fires in the cycle the counter first exceeds its limit. o_error is asserted on the following cycle.

## Test plan
- Reset check: assert i_rst for 3 cycles -> o_scaler=16; o_busy, o_valid and o_error all 0.
- Nominal: defaults, arm, send 0x55 with 128 clk/bit -> total=1024, o_valid pulse, o_scaler=16, o_busy low afterwards.
- Rounding and jitter:
  - 130 clk/bit -> o_scaler=16.
  - 100 clk/bit -> total=800 -> o_scaler=13.
  - OverSample=16 with 200 clk/bit -> (1600+64)>>7 = 13.
- Tolerance: 128 clk/bit, but the third interval is stretched to 330 clk (limit 320) -> o_error pulse, o_scaler keeps its prior value. Repeat with 318 clk -> o_valid.
- Timeout: arm, send only a start edge and hold i_rx low -> o_error exactly MaxInterval+1 counter cycles after the edge. Also send 0x00 after a valid I0 -> o_error at I0+(I0>>2)+1.
- Control: i_arm while busy is ignored, so the result comes from the first arm only. Reset asserted during MEASURE -> no pulse, o_scaler=16, and the next arm detects normally. A sub-minimum result (2 clk/bit, R=0) -> o_error.

Source files
------------

// File: rtl/uart_autobaud.sv
// Autobaud detector: times the falling edges of a 0x55 sync character
// and derives the prescaler divider in clocks per oversample tick.
module uart_autobaud #(
   parameter int InitialDivider = 16,
   parameter int OverSample     = 8,
   parameter int MaxInterval    = 262143
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_rx,
   input  logic        i_arm,
   output logic        o_busy,
   output logic [15:0] o_scaler,
   output logic        o_valid,
   output logic        o_error
);

   localparam int          Shift  = 3 + $clog2(OverSample);
   localparam logic [23:0] Half   = 24'(1) << (Shift - 1);
   localparam logic [20:0] MaxLim = 21'(MaxInterval);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_HIGH,
      WAIT_EDGE,
      MEASURE,
      RESULT
   } state_t;

   state_t state, state_d;

   logic        rx_m, rx_s, rx_q;
   logic        fall;
   logic [19:0] cnt;
   logic [19:0] i0;
   logic [22:0] total;
   logic [1:0]  idx;
   logic        err_d, val_d, take;
   logic [20:0] tol, lim, diff;
   logic        tmo, in_tol;
   logic [23:0] sum, r;
   logic        r_ok;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
         rx_q <= 1'b1;
      end else begin
         rx_m <= i_rx;
         rx_s <= rx_m;
         rx_q <= rx_s;
      end
   end

   assign fall   = rx_q & ~rx_s;
   assign o_busy = (state != IDLE);

   // Widened to 21 bits so the tolerance window never wraps.
   always_comb begin
      tol = {1'b0, i0} >> 2;
      lim = (idx == 2'd0) ? MaxLim : ({1'b0, i0} + tol);
      tmo = ({1'b0, cnt} > lim);
      if (cnt >= i0)
         diff = {1'b0, cnt} - {1'b0, i0};
      else
         diff = {1'b0, i0} - {1'b0, cnt};
      in_tol = (diff <= tol);
      sum    = {1'b0, total} + Half;
      r      = sum >> Shift;
      r_ok   = (r >= 24'd2) && (r <= 24'hFFFF);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst)
         state <= IDLE;
      else
         state <= state_d;
   end

   always_comb begin
      state_d = state;
      err_d   = 1'b0;
      val_d   = 1'b0;
      take    = 1'b0;
      unique case (state)
         IDLE: begin
            if (i_arm && !o_valid && !o_error)
               state_d = WAIT_HIGH;
         end
         WAIT_HIGH: begin
            if (rx_s)
               state_d = WAIT_EDGE;
         end
         WAIT_EDGE: begin
            if (fall)
               state_d = MEASURE;
         end
         MEASURE: begin
            if (tmo) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else if (fall) begin
               if (idx == 2'd0) begin
                  take = 1'b1;
               end else if (in_tol) begin
                  take = 1'b1;
                  if (idx == 2'd3)
                     state_d = RESULT;
               end else begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         RESULT: begin
            state_d = IDLE;
            if (r_ok)
               val_d = 1'b1;
            else
               err_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt      <= '0;
         i0       <= '0;
         total    <= '0;
         idx      <= '0;
         o_scaler <= 16'(InitialDivider);
         o_valid  <= 1'b0;
         o_error  <= 1'b0;
      end else begin
         o_valid <= val_d;
         o_error <= err_d;
         if (fall)
            cnt <= 20'd1;
         else if (!(&cnt))
            cnt <= cnt + 20'd1;
         if (state == WAIT_EDGE) begin
            idx   <= '0;
            total <= '0;
         end
         if (take) begin
            if (idx == 2'd0) begin
               i0    <= cnt;
               total <= {3'b000, cnt};
            end else begin
               total <= total + {3'b000, cnt};
            end
            idx <= idx + 2'd1;
         end
         if (val_d)
            o_scaler <= r[15:0];
      end
   end

endmodule

// File: tb/tb_uart_autobaud.sv
// Directed bench for uart_autobaud: sync frames at several rates,
// tolerance and timeout aborts, arm/reset control, OverSample=16.
module tb_uart_autobaud;

   localparam int MaxInt = 1000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx  = 1'b1;
   logic        arm_a = 1'b0;
   logic        arm_b = 1'b0;
   logic        busy_a, valid_a, error_a;
   logic        busy_b, valid_b, error_b;
   logic [15:0] scaler_a, scaler_b;

   int npass  = 0;
   int nfail  = 0;
   int ntotal = 0;
   int nv_a = 0, ne_a = 0, nv_b = 0, ne_b = 0, nboth = 0;

   always #5 clk = ~clk;

   uart_autobaud #(
      .InitialDivider(16), .OverSample(8), .MaxInterval(MaxInt)
   ) dut_a (
      .i_clk(clk), .i_rst(rst), .i_rx(rx), .i_arm(arm_a),
      .o_busy(busy_a), .o_scaler(scaler_a),
      .o_valid(valid_a), .o_error(error_a)
   );

   uart_autobaud #(
      .InitialDivider(16), .OverSample(16), .MaxInterval(MaxInt)
   ) dut_b (
      .i_clk(clk), .i_rst(rst), .i_rx(rx), .i_arm(arm_b),
      .o_busy(busy_b), .o_scaler(scaler_b),
      .o_valid(valid_b), .o_error(error_b)
   );

   always @(negedge clk) begin
      if (valid_a) nv_a++;
      if (error_a) ne_a++;
      if (valid_b) nv_b++;
      if (error_b) ne_b++;
      if ((valid_a && error_a) || (valid_b && error_b)) nboth++;
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      ntotal++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic arm(input bit b);
      if (b) arm_b = 1'b1;
      else arm_a = 1'b1;
      cyc(1);
      arm_a = 1'b0;
      arm_b = 1'b0;
      cyc(3);
   endtask

   // Drives five falling edges; iv[k] is the edge-to-edge spacing.
   task automatic send(input int bitp, input int i0, input int i1,
                       input int i2, input int i3, input bit mid);
      int iv[4];
      iv = '{i0, i1, i2, i3};
      for (int k = 0; k < 4; k++) begin
         rx = 1'b0;
         if (mid && k == 1) begin
            arm_a = 1'b1;
            cyc(1);
            arm_a = 1'b0;
            cyc(bitp - 1);
         end else begin
            cyc(bitp);
         end
         rx = 1'b1;
         cyc(iv[k] - bitp);
      end
      rx = 1'b0;
   endtask

   task automatic tail(input int bitp);
      cyc(bitp);
      rx = 1'b1;
      cyc(bitp + 8);
   endtask

   task automatic frame(input string tag, input int bitp, input int i2,
                        input bit mid, input int ev, input int ee,
                        input int esc);
      int v0, e0;
      v0 = nv_a;
      e0 = ne_a;
      arm(1'b0);
      send(bitp, 2 * bitp, 2 * bitp, i2, 2 * bitp, mid);
      tail(bitp);
      chk({tag, "_valid"}, nv_a - v0, ev);
      chk({tag, "_error"}, ne_a - e0, ee);
      chk({tag, "_scaler"}, scaler_a, esc);
      chk({tag, "_busy"}, busy_a, 0);
   endtask

   task automatic wait_err(input int limit, output int n);
      n = -1;
      for (int i = 1; i <= limit; i++) begin
         @(posedge clk);
         #1;
         if (error_a) begin
            n = i;
            break;
         end
      end
   endtask

   initial begin
      int n, v0, e0;

      cyc(3);
      chk("rst_scaler", scaler_a, 16);
      chk("rst_busy", busy_a, 0);
      chk("rst_valid", valid_a, 0);
      chk("rst_error", error_a, 0);
      chk("rst_scaler_b", scaler_b, 16);
      rst = 1'b0;
      cyc(2);

      // Nominal 128 clk/bit: total 1024, (1024+32)>>6 = 16.
      v0 = nv_a;
      arm_a = 1'b1;
      cyc(1);
      arm_a = 1'b0;
      chk("nom_busy_rise", busy_a, 1);
      cyc(3);
      send(128, 256, 256, 256, 256, 1'b0);
      cyc(3);
      chk("nom_valid_early", valid_a, 0);
      chk("nom_busy_held", busy_a, 1);
      cyc(1);
      chk("nom_valid", valid_a, 1);
      chk("nom_scaler", scaler_a, 16);
      chk("nom_busy_fall", busy_a, 0);
      arm_a = 1'b1;
      cyc(1);
      arm_a = 1'b0;
      chk("nom_pulse_1cyc", valid_a, 0);
      chk("arm_on_valid", busy_a, 0);
      tail(128);
      chk("nom_count", nv_a - v0, 1);

      // 130 -> (1040+32)>>6 = 16; 100 -> (800+32)>>6 = 13.
      frame("r130", 130, 260, 1'b0, 1, 0, 16);
      frame("r100", 100, 200, 1'b0, 1, 0, 13);

      // I0=256, window 64: 330 aborts, 318 passes.
      // 318 gives total 1086 -> (1086+32)>>6 = 17.
      frame("tol330", 128, 330, 1'b0, 0, 1, 13);
      frame("tol318", 128, 318, 1'b0, 1, 0, 17);

      // Edge driven after P1 reaches rx_s at P2; counter is 1 after P3
      // and exceeds MaxInt after P(MaxInt+3); error shows one edge later.
      arm(1'b0);
      rx = 1'b0;
      wait_err(MaxInt + 100, n);
      chk("tmo_first", n, MaxInt + 4);
      rx = 1'b1;
      cyc(5);
      chk("tmo_first_scaler", scaler_a, 17);

      // I0=256: limit 320, exceeded at count 321.
      arm(1'b0);
      rx = 1'b0;
      cyc(128);
      rx = 1'b1;
      cyc(128);
      rx = 1'b0;
      wait_err(500, n);
      chk("tmo_next", n, 256 + 64 + 4);
      rx = 1'b1;
      cyc(5);
      chk("tmo_next_scaler", scaler_a, 17);

      frame("arm_busy", 100, 200, 1'b1, 1, 0, 13);

      // Reset during MEASURE: no pulse, divider back to initial.
      arm(1'b0);
      v0 = nv_a;
      e0 = ne_a;
      rx = 1'b0;
      cyc(128);
      rx = 1'b1;
      cyc(128);
      rx = 1'b0;
      cyc(60);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      rx = 1'b1;
      chk("mrst_scaler", scaler_a, 16);
      chk("mrst_busy", busy_a, 0);
      cyc(8);
      chk("mrst_pulses", (nv_a - v0) + (ne_a - e0), 0);
      frame("after_rst", 100, 200, 1'b0, 1, 0, 13);

      // 2 clk/bit: (16+32)>>6 = 0, below minimum.
      frame("submin", 2, 4, 1'b0, 0, 1, 13);

      // OverSample=16, 200 clk/bit: (1600+64)>>7 = 13.
      v0 = nv_b;
      e0 = ne_b;
      arm(1'b1);
      send(200, 400, 400, 400, 400, 1'b0);
      tail(200);
      chk("os16_valid", nv_b - v0, 1);
      chk("os16_error", ne_b - e0, 0);
      chk("os16_scaler", scaler_b, 13);
      chk("os16_busy", busy_b, 0);

      chk("never_both", nboth, 0);

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
